// File: rtl/segment_transition_ctl.sv
// Read-segment switch scheduler for one double-buffered playback engine.
// Arms a transition on UPDATE_SETTINGS and flips SEGMENT when the selected condition hits.
module segment_transition_ctl #(
   parameter int unsigned SysTimeWidth = 64,
   parameter int unsigned NumGpio      = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    UPDATE_SETTINGS,
   input  logic                    REQ_RD_SEGMENT,
   input  logic [7:0]              TRANSITION_MODE,
   input  logic [63:0]             TRANSITION_VALUE,
   input  logic [SysTimeWidth-1:0] SYS_TIME,
   input  logic                    LOOP_END,
   input  logic [NumGpio-1:0]      GPIO_IN,
   output logic                    SEGMENT,
   output logic                    SEGMENT_SWAP,
   output logic                    PENDING,
   output logic                    LATE
);

   localparam logic [7:0] ModeSyncIdx = 8'h00;
   localparam logic [7:0] ModeSysTime = 8'h01;
   localparam logic [7:0] ModeGpio    = 8'h02;
   localparam logic [7:0] ModeExt     = 8'hF0;

   typedef enum logic [2:0] {
      StIdle,
      StWaitIdx,
      StWaitTime,
      StWaitGpio,
      StExt
   } state_e;

   state_e                  state_q, state_d;
   logic                    segment_q, segment_d;
   logic                    swap_q, swap_d;
   logic                    pending_q, pending_d;
   logic                    late_q, late_d;
   logic                    req_q, req_d;
   logic [SysTimeWidth-1:0] value_q, value_d;
   logic                    first_q, first_d;
   logic                    edge_q, edge_d;
   logic                    gpio_cur;
   logic                    gpio_new;
   logic                    hit;

   // Pin select for the armed request and for the one being latched this cycle.
   always_comb begin
      gpio_cur = 1'b0;
      gpio_new = 1'b0;
      for (int i = 0; i < int'(NumGpio); i++) begin
         if (value_q[1:0] == i[1:0]) gpio_cur = GPIO_IN[i];
         if (TRANSITION_VALUE[1:0] == i[1:0]) gpio_new = GPIO_IN[i];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= StIdle;
         segment_q <= 1'b0;
         swap_q    <= 1'b0;
         pending_q <= 1'b0;
         late_q    <= 1'b0;
         req_q     <= 1'b0;
         value_q   <= '0;
         first_q   <= 1'b0;
         edge_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         segment_q <= segment_d;
         swap_q    <= swap_d;
         pending_q <= pending_d;
         late_q    <= late_d;
         req_q     <= req_d;
         value_q   <= value_d;
         first_q   <= first_d;
         edge_q    <= edge_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      segment_d = segment_q;
      swap_d    = 1'b0;
      pending_d = pending_q;
      late_d    = late_q;
      req_d     = req_q;
      value_d   = value_q;
      first_d   = 1'b0;
      edge_d    = gpio_cur;
      hit       = 1'b0;

      if (UPDATE_SETTINGS) begin
         // A new request always discards the armed one, even on its hit cycle.
         req_d     = REQ_RD_SEGMENT;
         value_d   = TRANSITION_VALUE[SysTimeWidth-1:0];
         late_d    = 1'b0;
         edge_d    = gpio_new;
         pending_d = 1'b0;
         state_d   = StIdle;
         case (TRANSITION_MODE)
            ModeSyncIdx: begin
               if (REQ_RD_SEGMENT != segment_q) begin
                  state_d   = StWaitIdx;
                  pending_d = 1'b1;
               end
            end
            ModeSysTime: begin
               if (REQ_RD_SEGMENT != segment_q) begin
                  state_d   = StWaitTime;
                  pending_d = 1'b1;
                  first_d   = 1'b1;
               end
            end
            ModeGpio: begin
               if (REQ_RD_SEGMENT != segment_q) begin
                  state_d   = StWaitGpio;
                  pending_d = 1'b1;
               end
            end
            ModeExt: begin
               state_d = StExt;
               if (REQ_RD_SEGMENT != segment_q) begin
                  segment_d = REQ_RD_SEGMENT;
                  swap_d    = 1'b1;
               end
            end
            default: begin
               if (REQ_RD_SEGMENT != segment_q) begin
                  segment_d = REQ_RD_SEGMENT;
                  swap_d    = 1'b1;
               end
            end
         endcase
      end else begin
         unique case (state_q)
            StIdle:     ;
            StWaitIdx:  hit = LOOP_END;
            StWaitTime: begin
               if (SYS_TIME >= value_q) begin
                  hit    = 1'b1;
                  late_d = first_q;
               end
            end
            StWaitGpio: hit = gpio_cur & ~edge_q;
            StExt: begin
               if (LOOP_END) begin
                  segment_d = ~segment_q;
                  swap_d    = 1'b1;
               end
            end
            default:    state_d = StIdle;
         endcase
         if (hit) begin
            segment_d = req_q;
            swap_d    = 1'b1;
            pending_d = 1'b0;
            state_d   = StIdle;
         end
      end
   end

   assign SEGMENT      = segment_q;
   assign SEGMENT_SWAP = swap_q;
   assign PENDING      = pending_q;
   assign LATE         = late_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed bench for segment_transition_ctl; expected output vectors are queued per step
// and compared one cycle later against {SEGMENT, SEGMENT_SWAP, PENDING, LATE}.
module tb_segment_transition_ctl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        UPDATE_SETTINGS = 1'b0;
   logic        REQ_RD_SEGMENT = 1'b0;
   logic [7:0]  TRANSITION_MODE = 8'h00;
   logic [63:0] TRANSITION_VALUE = '0;
   logic [63:0] SYS_TIME = '0;
   logic        LOOP_END = 1'b0;
   logic [3:0]  GPIO_IN = '0;
   logic        SEGMENT, SEGMENT_SWAP, PENDING, LATE;

   typedef struct {
      string      tag;
      logic [3:0] vec;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   segment_transition_ctl #(
      .SysTimeWidth(64),
      .NumGpio(4)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .UPDATE_SETTINGS(UPDATE_SETTINGS),
      .REQ_RD_SEGMENT(REQ_RD_SEGMENT),
      .TRANSITION_MODE(TRANSITION_MODE),
      .TRANSITION_VALUE(TRANSITION_VALUE),
      .SYS_TIME(SYS_TIME),
      .LOOP_END(LOOP_END),
      .GPIO_IN(GPIO_IN),
      .SEGMENT(SEGMENT),
      .SEGMENT_SWAP(SEGMENT_SWAP),
      .PENDING(PENDING),
      .LATE(LATE)
   );

   always #5 CLK = ~CLK;

   // Expected {SEGMENT, SEGMENT_SWAP, PENDING, LATE} for the next observation point.
   task automatic push(input string tag, input logic seg, input logic sw, input logic pend,
                       input logic late);
      exp_t e;
      e.tag = tag;
      e.vec = {seg, sw, pend, late};
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t       e;
      logic [3:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = {SEGMENT, SEGMENT_SWAP, PENDING, LATE};
         checks++;
         assert (obs === e.vec) else begin
            errors++;
            $error("FAIL %s observed seg/swap/pend/late=%b expected=%b", e.tag, obs, e.vec);
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      drain();
      UPDATE_SETTINGS = 1'b0;
      LOOP_END        = 1'b0;
   endtask

   task automatic update(input logic req, input logic [7:0] mode, input logic [63:0] value);
      UPDATE_SETTINGS  = 1'b1;
      REQ_RD_SEGMENT   = req;
      TRANSITION_MODE  = mode;
      TRANSITION_VALUE = value;
   endtask

   initial begin
      // Reset state
      #1;
      push("reset_async", 0, 0, 0, 0);
      drain();
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      push("after_reset", 0, 0, 0, 0);
      tick();

      // SYNC_IDX: LOOP_END in the arming cycle must be ignored
      update(1'b1, 8'h00, 64'd0);
      LOOP_END = 1'b1;
      push("idx_arm", 0, 0, 1, 0);
      tick();
      for (int i = 2; i <= 10; i++) begin
         push("idx_wait", 0, 0, 1, 0);
         tick();
      end
      LOOP_END = 1'b1;
      push("idx_hit", 1, 1, 0, 0);
      tick();
      push("idx_after", 1, 0, 0, 0);
      tick();
      LOOP_END = 1'b1;
      push("idx_second_loop", 1, 0, 0, 0);
      tick();

      // SYS_TIME on time: target 1000, counting from 900
      SYS_TIME = 64'd900;
      update(1'b0, 8'h01, 64'd1000);
      push("time_arm", 1, 0, 1, 0);
      tick();
      for (int st = 901; st <= 1000; st++) begin
         SYS_TIME = 64'(st);
         if (st < 1000) push("time_wait", 1, 0, 1, 0);
         else           push("time_hit", 0, 1, 0, 0);
         tick();
      end

      // SYS_TIME already past: swap at t+2 with LATE
      SYS_TIME = 64'd1001;
      update(1'b1, 8'h01, 64'd500);
      push("late_arm", 0, 0, 1, 0);
      tick();
      SYS_TIME = 64'd1002;
      push("late_hit", 1, 1, 0, 1);
      tick();
      SYS_TIME = 64'd1003;
      push("late_sticky", 1, 0, 0, 1);
      tick();

      // GPIO pin 2, already high at arming; this update also clears LATE
      GPIO_IN = 4'b0100;
      update(1'b0, 8'h02, 64'd2);
      push("gpio_arm_late_clr", 1, 0, 1, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         push("gpio_level_high", 1, 0, 1, 0);
         tick();
      end
      GPIO_IN = 4'b0101;
      push("gpio_other_pin", 1, 0, 1, 0);
      tick();
      GPIO_IN = 4'b0100;
      push("gpio_other_pin", 1, 0, 1, 0);
      tick();
      GPIO_IN = 4'b0001;
      push("gpio_low", 1, 0, 1, 0);
      tick();
      GPIO_IN = 4'b0100;
      push("gpio_rise", 0, 1, 0, 0);
      tick();
      push("gpio_after", 0, 0, 0, 0);
      tick();

      // EXT: immediate swap then toggle on every LOOP_END
      update(1'b1, 8'hF0, 64'd0);
      push("ext_entry", 1, 1, 0, 0);
      tick();
      push("ext_idle", 1, 0, 0, 0);
      tick();
      LOOP_END = 1'b1;
      push("ext_loop1", 0, 1, 0, 0);
      tick();
      LOOP_END = 1'b1;
      push("ext_loop2", 1, 1, 0, 0);
      tick();
      push("ext_idle2", 1, 0, 0, 0);
      tick();
      LOOP_END = 1'b1;
      push("ext_loop3", 0, 1, 0, 0);
      tick();
      update(1'b0, 8'h00, 64'd0);
      push("ext_exit_same", 0, 0, 0, 0);
      tick();
      LOOP_END = 1'b1;
      push("idle_loop_ignored", 0, 0, 0, 0);
      tick();

      // UPDATE collides with the old request's hit cycle
      SYS_TIME = 64'd1500;
      update(1'b1, 8'h01, 64'd2000);
      push("coll_arm", 0, 0, 1, 0);
      tick();
      SYS_TIME = 64'd1600;
      push("coll_wait", 0, 0, 1, 0);
      tick();
      SYS_TIME = 64'd2000;
      update(1'b0, 8'h00, 64'd0);
      push("coll_discard", 0, 0, 0, 0);
      tick();
      push("coll_after", 0, 0, 0, 0);
      tick();

      // Unknown mode: immediate swap, then IDLE
      update(1'b1, 8'h07, 64'd0);
      push("unk_swap", 1, 1, 0, 0);
      tick();
      push("unk_after", 1, 0, 0, 0);
      tick();
      LOOP_END = 1'b1;
      push("unk_idle_loop", 1, 0, 0, 0);
      tick();

      // Reset in the middle of a SYNC_IDX wait
      update(1'b0, 8'h00, 64'd0);
      push("rst_arm", 1, 0, 1, 0);
      tick();
      push("rst_wait", 1, 0, 1, 0);
      tick();
      RST = 1'b1;
      #1;
      push("rst_async", 0, 0, 0, 0);
      drain();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      LOOP_END = 1'b1;
      push("rst_loop_no_swap", 0, 0, 0, 0);
      tick();
      push("rst_quiet", 0, 0, 0, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
